fetch_skid_buffer: RTL and testbench

Registered two-entry skid buffer between the combinational fetch stage and decode. It captures the PC, instruction word and access-fault flag produced by fetch, and presents them to decode through a valid/ready handshake. It breaks every combinational path between the two stages in both directions. Flushes discard all buffered instructions when a branch, jump or trap redirects the PC.

---
 rtl/fetch_skid_buffer_pkg.sv | 24 ++
 rtl/fetch_skid_buffer.sv | 112 +++++++++++
 tb/tb_fetch_skid_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_skid_buffer_pkg.sv
// Shared fetch/decode types: captured entry layout, occupancy states and the fault NOP.
package fetch_skid_buffer_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- substituted for the instruction word of a faulted fetch
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } skid_state_t;

  // Entry value held while nothing valid is stored
  localparam fetch_entry_t RESET_ENTRY = '{pc: '0, inst: NOP_INST, fault: 1'b0};

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry registered skid buffer between fetch and decode. Every output is a
// flop (or decoded purely from state), so no combinational path crosses it.
module fetch_skid_buffer
  import fetch_skid_buffer_pkg::*;
#(
  parameter int unsigned     WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] NOP_INST = fetch_skid_buffer_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic [WIDTH-1:0] fetch_inst,
  input  logic             fetch_fault,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_pc,
  output logic [WIDTH-1:0] dec_inst,
  output logic             dec_fault
);

  skid_state_t  state_q, state_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t skid_q;
  fetch_entry_t cap_entry;
  logic         head_load;
  logic         skid_load;
  logic         push;
  logic         pop;

  assign push = fetch_valid & fetch_ready;
  assign pop  = dec_valid & dec_ready;

  // Fault substitution happens here, on capture; the PC is kept for mepc
  always_comb begin
    cap_entry.pc    = fetch_pc;
    cap_entry.inst  = fetch_fault ? NOP_INST : fetch_inst;
    cap_entry.fault = fetch_fault;
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy; flush wins over any push or pop
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop)      state_d = StFull;
          else if (!push && pop) state_d = StEmpty;
        end
        StFull:  if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Handshake outputs decoded from state only
  always_comb begin
    fetch_ready = (state_q != StFull);
    dec_valid   = (state_q != StEmpty);
  end

  // Data load enables; a flushed cycle loads nothing so dec_* hold their values
  always_comb begin
    head_load = 1'b0;
    skid_load = 1'b0;
    head_d    = cap_entry;
    if (!flush) begin
      unique case (state_q)
        StEmpty: head_load = push;
        StOne: begin
          head_load = push & pop;
          skid_load = push & ~pop;
        end
        StFull: begin
          head_load = pop;
          head_d    = skid_q;
        end
        default: ;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= RESET_ENTRY;
      skid_q <= RESET_ENTRY;
    end else begin
      if (head_load) head_q <= head_d;
      if (skid_load) skid_q <= cap_entry;
    end
  end

  assign dec_pc    = head_q.pc;
  assign dec_inst  = head_q.inst;
  assign dec_fault = head_q.fault;

endmodule

// File: tb/tb_fetch_skid_buffer.sv
// Directed plus random stimulus with a queue scoreboard for fetch_skid_buffer.
module tb_fetch_skid_buffer;
  import fetch_skid_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_fault;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_fault;

  fetch_entry_t sb_q[$];
  int          vectors = 0;
  int          errs    = 0;
  int          pops    = 0;
  bit          last_accept;

  fetch_skid_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .fetch_fault(fetch_fault),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_pc     (dec_pc),
    .dec_inst   (dec_inst),
    .dec_fault  (dec_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic fault);
    fetch_entry_t e;
    e.pc    = pc;
    e.inst  = fault ? 32'h0000_0013 : inst;
    e.fault = fault;
    return e;
  endfunction

  // One clock: check occupancy, score a pop, record a push, then step past the edge
  task automatic tick();
    bit push, pop;
    fetch_entry_t e;
    @(negedge clk);
    chk("dec_valid", {31'b0, dec_valid}, {31'b0, sb_q.size() > 0});
    chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, sb_q.size() < 2});
    push = fetch_valid && (sb_q.size() < 2);
    pop  = (sb_q.size() > 0) && dec_ready;
    if (pop) begin
      e = sb_q.pop_front();
      chk("dec_pc", dec_pc, e.pc);
      chk("dec_inst", dec_inst, e.inst);
      chk("dec_fault", {31'b0, dec_fault}, {31'b0, e.fault});
      pops++;
    end
    if (flush) sb_q.delete();
    else if (push) sb_q.push_back(mk(fetch_pc, fetch_inst, fetch_fault));
    last_accept = push && !flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    logic [31:0] pc_r;
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    fetch_pc = '0; fetch_inst = '0; fetch_fault = 1'b0;

    // Reset state
    #12;
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0000_0013);
    chk("rst_dec_fault", {31'b0, dec_fault}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Streaming: 8 pushes, one delivery per cycle
    dec_ready = 1'b1; fetch_valid = 1'b1; p0 = pops;
    for (int i = 0; i < 8; i++) begin
      fetch_pc = 32'(i * 4); fetch_inst = 32'h1000_0000 + 32'(i);
      tick();
    end
    fetch_valid = 1'b0;
    tick();
    chk("stream_count", 32'(pops - p0), 32'd8);

    // Backpressure into FULL, then drain with re-offer
    dec_ready = 1'b0; fetch_valid = 1'b1; p0 = pops;
    fetch_pc = 32'h100; fetch_inst = 32'hA100; tick();
    fetch_pc = 32'h104; fetch_inst = 32'hA104; tick();
    fetch_pc = 32'h108; fetch_inst = 32'hA108;
    #1 chk("bp_full_ready", {31'b0, fetch_ready}, 32'd0);
    tick();
    dec_ready = 1'b1;
    for (int i = 0; i < 5 && !last_accept; i++) tick();
    chk("bp_reoffer_taken", {31'b0, last_accept}, 32'd1);
    fetch_valid = 1'b0;
    tick();
    chk("bp_count", 32'(pops - p0), 32'd3);

    // Fault substitution on capture
    dec_ready = 1'b0; fetch_valid = 1'b1;
    fetch_pc = 32'h0001_0000; fetch_inst = 32'hDEAD_BEEF; fetch_fault = 1'b1;
    tick();
    fetch_valid = 1'b0; fetch_fault = 1'b0;
    chk("fault_inst", dec_inst, 32'h0000_0013);
    chk("fault_flag", {31'b0, dec_fault}, 32'd1);
    chk("fault_pc", dec_pc, 32'h0001_0000);
    dec_ready = 1'b1;
    tick();

    // Flush from FULL with a simultaneous offer
    dec_ready = 1'b0; fetch_valid = 1'b1;
    fetch_pc = 32'h300; fetch_inst = 32'hB300; tick();
    fetch_pc = 32'h304; fetch_inst = 32'hB304; tick();
    flush = 1'b1; fetch_pc = 32'h200; fetch_inst = 32'hB200;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    chk("flush_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("flush_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("flush_dec_pc_held", dec_pc, 32'h300);
    dec_ready = 1'b1; p0 = pops;
    tick(); tick();
    chk("flush_nothing_out", 32'(pops - p0), 32'd0);

    // Asynchronous reset while holding one entry
    dec_ready = 1'b0; fetch_valid = 1'b1;
    fetch_pc = 32'h400; fetch_inst = 32'hC400; fetch_fault = 1'b1;
    tick();
    fetch_valid = 1'b0; fetch_fault = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("arst_dec_fault", {31'b0, dec_fault}, 32'd0);
    chk("arst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("arst_dec_pc", dec_pc, 32'h0);
    sb_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    fetch_valid = 1'b1; fetch_pc = 32'h500; fetch_inst = 32'hC500;
    tick();
    fetch_valid = 1'b0;
    chk("arst_first_pc", dec_pc, 32'h500);
    dec_ready = 1'b1;
    tick();

    // Random handshakes against the scoreboard
    pc_r = 32'h8000_0000;
    fetch_pc = pc_r; fetch_inst = $urandom; fetch_fault = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      fetch_valid = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      tick();
      if (last_accept) begin
        pc_r        = pc_r + 32'd4;
        fetch_pc    = pc_r;
        fetch_inst  = $urandom;
        fetch_fault = ($urandom_range(0, 7) == 0);
      end
    end

    // Drain
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b1;
    tick(); tick(); tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_dec_valid", {31'b0, dec_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
